// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the wide-op ALU sequencer.
package alu_seq_pkg;

    // Sequencer states: compare-mode bracket around the two byte steps.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MODE_ON  = 3'd1,
        ST_LO       = 3'd2,
        ST_HI       = 3'd3,
        ST_MODE_OFF = 3'd4,
        ST_RESP     = 3'd5
    } state_t;

    // Wide operations, encoded as on the w_op port.
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_CMP = 2'd3
    } op_t;

    // ALU compare-mode control instructions.
    localparam logic [7:0] CLR_CMP = 8'h40;
    localparam logic [7:0] CMP_OFF = 8'h41;
    localparam logic [7:0] CMP_ON  = 8'h42;

    // ALU instruction used for each byte step of a wide op; CMP is a SUB
    // whose result is discarded.
    function automatic logic [7:0] op_cins(input op_t op,
                                           input logic [7:0] cins_add,
                                           input logic [7:0] cins_sub,
                                           input logic [7:0] cins_and);
        case (op)
            OP_ADD:  return cins_add;
            OP_AND:  return cins_and;
            default: return cins_sub;
        endcase
    endfunction

endpackage

// File: rtl/alu_wide_seq.sv
// Arbiter/sequencer in front of the 8-bit ALU. Direct byte ops pass straight
// through while idle; 16-bit wide ops run as low byte then high byte with the
// carry chained through the ALU compare-mode carry input.
module alu_wide_seq
    import alu_seq_pkg::*;
#(
    parameter logic [7:0] CINS_ADD = 8'h01,
    parameter logic [7:0] CINS_SUB = 8'h09,
    parameter logic [7:0] CINS_AND = 8'h11
) (
    input  logic        clk,
    input  logic        rst,
    // direct byte-op path
    input  logic        d_valid,
    input  logic [7:0]  d_a,
    input  logic [7:0]  d_b,
    input  logic [7:0]  d_cins,
    input  logic        d_oe,
    input  logic        d_carry,
    output logic        d_stall,
    // wide request / response
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [1:0]  w_op,
    input  logic [15:0] w_a,
    input  logic [15:0] w_b,
    output logic        r_valid,
    output logic [15:0] r_data,
    output logic        r_carry,
    output logic        r_over,
    output logic        r_zero,
    // ALU ports
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [7:0]  alu_cins,
    output logic        alu_oe,
    output logic        alu_carryin,
    input  logic [7:0]  alu_out,
    input  logic        alu_carryout,
    input  logic        alu_overout
);

    state_t      state_reg;
    op_t         op_reg;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [7:0]  res_lo_reg;
    logic        c_lo_reg;
    logic [7:0]  res_hi_reg;
    logic        c_hi_reg;
    logic        o_hi_reg;
    logic        cmp_sh_reg;

    logic        r_valid_reg;
    logic [15:0] r_data_reg;
    logic        r_carry_reg;
    logic        r_over_reg;
    logic        r_zero_reg;

    logic [7:0]  seq_cins;
    logic        sub_like;
    logic        accept;
    logic        resp_load;
    logic [7:0]  hi_byte;
    logic        hi_carry;
    logic        hi_over;
    logic [15:0] wide_res;

    assign seq_cins = op_cins(op_reg, CINS_ADD, CINS_SUB, CINS_AND);
    assign sub_like = (op_reg == OP_SUB) || (op_reg == OP_CMP);

    // Direct path always wins the idle cycle; anything else stalls it.
    assign w_ready = (state_reg == ST_IDLE) && !d_valid;
    assign d_stall = d_valid && (state_reg != ST_IDLE);
    assign accept  = w_valid && w_ready;

    // With the mode already on there is no MODE_OFF step, so the response is
    // built straight from the live high-byte ALU result in HI.
    assign resp_load = ((state_reg == ST_HI) && cmp_sh_reg) || (state_reg == ST_MODE_OFF);
    assign hi_byte   = (state_reg == ST_HI) ? alu_out      : res_hi_reg;
    assign hi_carry  = (state_reg == ST_HI) ? alu_carryout : c_hi_reg;
    assign hi_over   = (state_reg == ST_HI) ? alu_overout  : o_hi_reg;
    assign wide_res  = {hi_byte, res_lo_reg};

    assign r_valid = r_valid_reg;
    assign r_data  = r_data_reg;
    assign r_carry = r_carry_reg;
    assign r_over  = r_over_reg;
    assign r_zero  = r_zero_reg;

    // ALU port mux: passthrough when idle, sequencer drive otherwise.
    always_comb begin
        alu_a       = 8'h00;
        alu_b       = 8'h00;
        alu_cins    = 8'h00;
        alu_oe      = 1'b0;
        alu_carryin = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (d_valid) begin
                    alu_a       = d_a;
                    alu_b       = d_b;
                    alu_cins    = d_cins;
                    alu_oe      = d_oe;
                    alu_carryin = d_carry;
                end
            end
            ST_MODE_ON: begin
                alu_cins = CMP_ON;
            end
            ST_LO: begin
                alu_a       = a_reg[7:0];
                alu_b       = b_reg[7:0];
                alu_cins    = seq_cins;
                alu_oe      = 1'b1;
                alu_carryin = sub_like;
            end
            ST_HI: begin
                alu_a       = a_reg[15:8];
                alu_b       = b_reg[15:8];
                alu_cins    = seq_cins;
                alu_oe      = 1'b1;
                alu_carryin = (op_reg != OP_AND) && c_lo_reg;
            end
            ST_MODE_OFF: begin
                alu_cins = CMP_OFF;
            end
            default: begin
            end
        endcase
    end

    // Sequencer FSM, compare-mode shadow and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_ADD;
            a_reg       <= 16'h0000;
            b_reg       <= 16'h0000;
            res_lo_reg  <= 8'h00;
            c_lo_reg    <= 1'b0;
            res_hi_reg  <= 8'h00;
            c_hi_reg    <= 1'b0;
            o_hi_reg    <= 1'b0;
            cmp_sh_reg  <= 1'b0;
            r_valid_reg <= 1'b0;
            r_data_reg  <= 16'h0000;
            r_carry_reg <= 1'b0;
            r_over_reg  <= 1'b0;
            r_zero_reg  <= 1'b0;
        end else begin
            r_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (d_valid) begin
                        // Track the compare mode the CPU leaves the ALU in.
                        if (d_cins == CMP_ON) begin
                            cmp_sh_reg <= 1'b1;
                        end else if (d_cins == CMP_OFF) begin
                            cmp_sh_reg <= 1'b0;
                        end
                    end else if (accept) begin
                        op_reg    <= op_t'(w_op);
                        a_reg     <= w_a;
                        b_reg     <= w_b;
                        state_reg <= cmp_sh_reg ? ST_LO : ST_MODE_ON;
                    end
                end
                ST_MODE_ON: begin
                    state_reg <= ST_LO;
                end
                ST_LO: begin
                    res_lo_reg <= alu_out;
                    c_lo_reg   <= alu_carryout;
                    state_reg  <= ST_HI;
                end
                ST_HI: begin
                    res_hi_reg <= alu_out;
                    c_hi_reg   <= alu_carryout;
                    o_hi_reg   <= alu_overout;
                    state_reg  <= cmp_sh_reg ? ST_RESP : ST_MODE_OFF;
                end
                ST_MODE_OFF: begin
                    state_reg <= ST_RESP;
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            if (resp_load) begin
                r_valid_reg <= 1'b1;
                r_data_reg  <= (op_reg == OP_CMP) ? 16'h0000 : wide_res;
                r_zero_reg  <= (wide_res == 16'h0000);
                r_carry_reg <= hi_carry;
                r_over_reg  <= hi_over;
            end
        end
    end

endmodule

// File: doc/alu_wide_seq.md
# alu_wide_seq

Arbiter and sequencer in front of the 8-bit ALU, and the only block that drives the ALU input ports. It shares the ALU between the CPU's direct byte-op path (passthrough) and a 16-bit wide-op request port. It runs each 16-bit ADD/SUB/AND/CMP as a multi-cycle sequence: low byte, then high byte, with carry chained through the ALU's compare-mode carry input. On completion it restores the ALU compare-mode state to what the CPU last set.

## Interface
Parameters:
- CINS_ADD, default 8'h01: ALU instruction for A+B (sum select, no inversions).
- CINS_SUB, default 8'h09: ALU instruction for A+~B (sum select, ib=1).
- CINS_AND, default 8'h11: ALU instruction for A&B (and select).
- The three rows above must match alu_rom.mem.

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  async reset, active-high
- d_valid  in  1  direct byte op present this cycle
- d_a, d_b  in  8  direct operands
- d_cins  in  8  direct ALU instruction
- d_oe, d_carry  in  1  direct output enable / carry-in
- d_stall  out  1  direct op not applied this cycle
- w_valid  in  1  wide request valid
- w_ready  out  1  wide request accepted when w_valid && w_ready
- w_op  in  2  0 ADD, 1 SUB, 2 AND, 3 CMP
- w_a, w_b  in  16  wide operands
- r_valid  out  1  one-cycle result strobe
- r_data  out  16  wide result
- r_carry, r_over, r_zero  out  1  result flags
- alu_a, alu_b  out  8  ALU operands
- alu_cins  out  8  ALU instruction
- alu_oe, alu_carryin  out  1  ALU output enable / carry-in
- alu_out  in  8  ALU result
- alu_carryout, alu_overout  in  1  ALU flags

## Operation
- States: IDLE, MODE_ON, LO, HI, MODE_OFF, RESP.
- IDLE:
  - ALU ports are a combinational passthrough of the d_* inputs.
  - When d_valid=0, ALU ports are all zero.
  - w_ready = (state==IDLE) && !d_valid. The direct path has priority.
- Shadow register `cmp_sh`:
  - Set when a direct op is applied with d_cins=8'h42.
  - Cleared when a direct op is applied with d_cins=8'h41.
  - Reset value 0.
- Accept: latch w_op, w_a, w_b. Next state is MODE_ON if cmp_sh=0, else LO.
- MODE_ON: alu_cins=8'h42, all other ALU outputs 0.
- LO:
  - alu_a=a[7:0], alu_b=b[7:0], alu_oe=1, alu_cins from op (CMP uses CINS_SUB).
  - alu_carryin = 1 for SUB/CMP, 0 otherwise.
  - Latch alu_out into res_lo and alu_carryout into c_lo.
- HI:
  - Same drive on the high bytes.
  - alu_carryin = c_lo for ADD/SUB/CMP, 0 for AND.
  - Latch alu_out, alu_carryout and alu_overout.
  - Next state is MODE_OFF if cmp_sh=0, else RESP.
- MODE_OFF: alu_cins=8'h41, other ALU outputs 0.
- RESP:
  - r_valid=1 for exactly this cycle, then IDLE.
  - r_data = {hi, lo}; CMP forces r_data=16'h0000.
  - r_zero = ({hi, lo}==0), computed on the difference for CMP.
  - r_carry / r_over = high-byte carryout / overout.
- r_data and flags hold until the next RESP.
- d_stall = d_valid && state!=IDLE. Stalled direct ops do not update cmp_sh.

## Timing
- Accept edge = cycle 0.
- cmp_sh=0: MODE_ON at 1, LO at 2, HI at 3, MODE_OFF at 4, RESP (r_valid) at 5. Next accept possible at 6.
- cmp_sh=1: LO at 1, HI at 2, RESP at 3.
- rst asserted at any time, including mid-sequence:
  - state→IDLE, cmp_sh=0.
  - r_valid, r_data, r_carry, r_over, r_zero all 0.
  - Latched operands cleared. No response is issued for the aborted op.
  - The ALU resets its own mode in the same event.
- Registered outputs reset to 0. w_ready, d_stall and ALU ports are combinational from state and d_*.
- d_valid and w_valid in the same IDLE cycle: the direct op executes and w_ready=0. The wide request is accepted on the first later IDLE cycle with d_valid=0.

## Structure
- Package alu_seq_pkg holds:
  - state enum;
  - op enum (ADD/SUB/AND/CMP);
  - constants CLR_CMP=8'h40, CMP_OFF=8'h41, CMP_ON=8'h42.
- Single module, no sub-module. The passthrough mux and the FSM are small enough to live together.

## Test plan
- ADD 0x12FF+0x0001, cmp_sh=0 → alu_cins sequence 42, CINS_ADD, CINS_ADD, 41. r_valid at cycle 5, r_data=0x1300, carry=0, zero=0.
- SUB 0x0100−0x0001 → r_data=0x00FF, carry=1. CMP 0x1234 vs 0x1234 → r_data=0, zero=1, carry=1.
- Direct op d_cins=42, then ADD 0xFFFF+0x0001 → no MODE_ON/MODE_OFF, r_valid at cycle 3, r_data=0, carry=1, zero=1, cmp_sh stays 1.
- d_valid and w_valid together in IDLE → direct op on the ALU, w_ready=0; accepted the next cycle. d_valid during LO → d_stall=1, alu_cins shows the sequencer's value.
- ADD 0x7FFF+0x0001 → 0x8000, over=1. AND 0xF0F0&0x0FFF → 0x00F0, carry=0.
- rst pulse during HI → IDLE, all registered outputs 0, no r_valid, cmp_sh=0. A following ADD runs the full 5-cycle sequence.
